// File: rtl/nark_pkg.sv
// Shared NARK pipeline control types: condition codes, forward selects and the decode control bundle.
// Used by nark_pipe_ctrl (optional feature macro: NARK_FWD_EN).
package nark_pkg;

  typedef enum logic [3:0] {
    COND_EQ  = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI  = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI  = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT  = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_AL2 = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       memtoreg;
    logic       alusrc;
    logic       nowrite;
    logic [1:0] flagwrite;
    cond_e      cond;
  } ctrl_t;

  // Flags are ordered NZCV, N in bit 3.
  function automatic logic cond_holds(input cond_e cond, input logic [3:0] nzcv);
    logic n, z, c, v, ok;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = ~(n ^ v);
      COND_LT: ok = n ^ v;
      COND_GT: ok = ~z & ~(n ^ v);
      COND_LE: ok = z | (n ^ v);
      COND_AL, COND_AL2: ok = 1'b1;
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/nark_stage_reg.sv
// Generic pipeline stage register: async active-low reset, synchronous clear (bubble) over enable.
module nark_stage_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage storage: clear wins over enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/nark_pipe_ctrl.sv
// NARK pipeline control: E/M/W control registers, condition evaluation, NZCV flags, stall/flush/forward.
// Build option NARK_FWD_EN enables operand forwarding; without it RAW hazards on E/M stall decode.
module nark_pipe_ctrl
  import nark_pkg::*;
#(
  parameter int RA_W   = 4,
  parameter int ALUC_W = 2,
  parameter int COND_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PCSrcD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              MemtoRegD,
  input  logic              ALUSrcD,
  input  logic              NoWriteD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [1:0]        FlagWriteD,
  input  logic [COND_W-1:0] CondD,
  input  logic [RA_W-1:0]   RA1D,
  input  logic [RA_W-1:0]   RA2D,
  input  logic [RA_W-1:0]   WA_D,
  input  logic [3:0]        ALUFlags,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ALUSrcE,
  output logic              MemWriteM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              PCSrcW,
  output logic              BranchTakenE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic [3:0]        Flags
);

  localparam int E_W = $bits(ctrl_t) + ALUC_W + 3 * RA_W;
  localparam int M_W = 4 + RA_W;
  localparam int W_W = 3 + RA_W;
`ifdef NARK_FWD_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  ctrl_t             ctrl_d_s, ctrl_e_s;
  logic [ALUC_W-1:0] aluc_e_s;
  logic [RA_W-1:0]   wa_e_s, ra1_e_s, ra2_e_s, wa_m_s, wa_w_s;
  logic [E_W-1:0]    e_q_s;
  logic [M_W-1:0]    m_d_s, m_q_s;
  logic [W_W-1:0]    w_q_s;
  logic              pcsrc_m_s, regwrite_m_s, memwrite_m_s, memtoreg_m_s;
  logic              pcsrc_w_s, regwrite_w_s, memtoreg_w_s;
  logic              cond_ex_s, taken_s, hit_e_s, hit_m_s;
  logic              data_stall_s, pc_pending_s, clear_e_s;
  fwd_e              fwd_a_s, fwd_b_s;
  logic [3:0]        flags_r;

  function automatic fwd_e fwd_pick(input logic [RA_W-1:0] src,
                                    input logic [RA_W-1:0] wa_m, input logic rw_m,
                                    input logic [RA_W-1:0] wa_w, input logic rw_w);
    fwd_e sel;
    if (rw_m && (wa_m == src)) begin
      sel = FWD_M;
    end else if (rw_w && (wa_w == src)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Bundle the decode control bits for the D->E register.
  always_comb begin
    ctrl_d_s = '{pcsrc: PCSrcD, regwrite: RegWriteD, memwrite: MemWriteD, branch: BranchD,
                 memtoreg: MemtoRegD, alusrc: ALUSrcD, nowrite: NoWriteD,
                 flagwrite: FlagWriteD, cond: cond_e'(CondD)};
  end

  nark_stage_reg #(.WIDTH(E_W)) u_reg_e (
    .clk(CLK), .rst_n(RST), .en(1'b1), .clr(clear_e_s),
    .d({ctrl_d_s, ALUControlD, WA_D, RA1D, RA2D}), .q(e_q_s)
  );
  assign {ctrl_e_s, aluc_e_s, wa_e_s, ra1_e_s, ra2_e_s} = e_q_s;

  // Condition check in E; side effects leave E already gated.
  always_comb begin
    cond_ex_s = cond_holds(ctrl_e_s.cond, flags_r);
    taken_s   = ctrl_e_s.branch & cond_ex_s;
    m_d_s     = {ctrl_e_s.pcsrc & cond_ex_s,
                 ctrl_e_s.regwrite & cond_ex_s & ~ctrl_e_s.nowrite,
                 ctrl_e_s.memwrite & cond_ex_s,
                 ctrl_e_s.memtoreg, wa_e_s};
  end

  nark_stage_reg #(.WIDTH(M_W)) u_reg_m (
    .clk(CLK), .rst_n(RST), .en(1'b1), .clr(1'b0), .d(m_d_s), .q(m_q_s)
  );
  assign {pcsrc_m_s, regwrite_m_s, memwrite_m_s, memtoreg_m_s, wa_m_s} = m_q_s;

  nark_stage_reg #(.WIDTH(W_W)) u_reg_w (
    .clk(CLK), .rst_n(RST), .en(1'b1), .clr(1'b0),
    .d({pcsrc_m_s, regwrite_m_s, memtoreg_m_s, wa_m_s}), .q(w_q_s)
  );
  assign {pcsrc_w_s, regwrite_w_s, memtoreg_w_s, wa_w_s} = w_q_s;

  // Architectural NZCV: N,Z and C,V pairs update independently.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      flags_r <= 4'b0000;
    end else begin
      if (ctrl_e_s.flagwrite[1] & cond_ex_s) begin
        flags_r[3:2] <= ALUFlags[3:2];
      end else begin
        flags_r[3:2] <= flags_r[3:2];
      end
      if (ctrl_e_s.flagwrite[0] & cond_ex_s) begin
        flags_r[1:0] <= ALUFlags[1:0];
      end else begin
        flags_r[1:0] <= flags_r[1:0];
      end
    end
  end

  // Hazards: with forwarding only a load in E stalls; without it any E/M writer match does.
  always_comb begin
    hit_e_s      = ctrl_e_s.regwrite & ((wa_e_s == RA1D) | (wa_e_s == RA2D));
    hit_m_s      = regwrite_m_s & ((wa_m_s == RA1D) | (wa_m_s == RA2D));
    data_stall_s = (hit_e_s & (ctrl_e_s.memtoreg | ~FWD_ON)) | (hit_m_s & ~FWD_ON);
    pc_pending_s = PCSrcD | ctrl_e_s.pcsrc | pcsrc_m_s;
    clear_e_s    = data_stall_s | taken_s;
    fwd_a_s      = fwd_pick(ra1_e_s, wa_m_s, regwrite_m_s, wa_w_s, regwrite_w_s);
    fwd_b_s      = fwd_pick(ra2_e_s, wa_m_s, regwrite_m_s, wa_w_s, regwrite_w_s);
  end

  assign ALUControlE  = aluc_e_s;
  assign ALUSrcE      = ctrl_e_s.alusrc;
  assign MemWriteM    = memwrite_m_s;
  assign RegWriteW    = regwrite_w_s;
  assign MemtoRegW    = memtoreg_w_s;
  assign PCSrcW       = pcsrc_w_s;
  assign BranchTakenE = taken_s;
  assign ForwardAE    = FWD_ON ? fwd_a_s : FWD_RF;
  assign ForwardBE    = FWD_ON ? fwd_b_s : FWD_RF;
  assign StallF       = RST & (data_stall_s | pc_pending_s);
  assign StallD       = RST & data_stall_s;
  assign FlushD       = RST & (pc_pending_s | taken_s);
  assign Flags        = flags_r;

endmodule
